// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Optional feature macro: IRQ_ZSAVE_EN (Z flag save/restore around handlers).
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [5:0] OP_RETI          = 6'b001111;
    localparam logic [9:0] VEC_BASE_DEFAULT = 10'h3F0;

    // Width of a line index; a single line still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side signal bundle of the interrupt controller.
// master = datapath/control unit side, slave = irq_ctrl side.
interface irq_ctrl_if #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned PC_W  = 10
);
    logic [N_IRQ-1:0] irq;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_in;
    logic [5:0]       opcode;
    logic [PC_W-1:0]  pc_next;
    logic             z_in;
    logic             s_irq;
    logic [PC_W-1:0]  pc_irq;
    logic [N_IRQ-1:0] irq_ack;
    logic             in_service;
    logic             z_restore;
    logic             z_out;

    modport master (
        output irq, mask_we, mask_in, opcode, pc_next, z_in,
        input  s_irq, pc_irq, irq_ack, in_service, z_restore, z_out
    );

    modport slave (
        input  irq, mask_we, mask_in, opcode, pc_next, z_in,
        output s_irq, pc_irq, irq_ack, in_service, z_restore, z_out
    );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending lines.
module prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // First set bit scanning upward from line 0 wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: edge-latched requests, fixed priority,
// PC override to VEC_BASE+line, return PC (and optionally Z) restore on RETI.
// Optional feature macro: IRQ_ZSAVE_EN -- when undefined z_restore/z_out are 0.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned     N_IRQ    = 4,
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = PC_W'(VEC_BASE_DEFAULT)
) (
    input  logic       clk,
    input  logic       reset,
    irq_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(N_IRQ);

    irq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [PC_W-1:0]  ret_pc_q, ret_pc_d;

    logic [N_IRQ-1:0] req_en;
    logic             enc_valid;
    logic [IDX_W-1:0] enc_idx;

    logic             s_irq;
    logic [PC_W-1:0]  pc_irq;
    logic [N_IRQ-1:0] irq_ack;
    logic             in_service;
    logic             reti;

    assign req_en = pending_q & mask_q;

    prio_enc #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (req_en),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Next-state and output decode from registered state plus opcode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        s_irq      = 1'b0;
        pc_irq     = '0;
        irq_ack    = '0;
        in_service = 1'b0;
        reti       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    idx_d   = enc_idx;
                    state_d = ENTER;
                end
            end
            ENTER: begin
                s_irq          = 1'b1;
                pc_irq         = VEC_BASE + PC_W'(idx_q);
                irq_ack[idx_q] = 1'b1;
                state_d        = SERVICE;
            end
            SERVICE: begin
                in_service = 1'b1;
                if (bus.opcode == OP_RETI) begin
                    reti    = 1'b1;
                    s_irq   = 1'b1;
                    pc_irq  = ret_pc_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge in the acknowledge cycle must survive the clear, so set is OR'd last.
    always_comb begin
        pending_d = (pending_q & ~irq_ack) | (bus.irq & ~irq_prev_q);
        mask_d    = bus.mask_we ? bus.mask_in : mask_q;
        ret_pc_d  = (state_q == ENTER) ? bus.pc_next : ret_pc_q;
    end

    // State, winning index, request tracking, mask and return PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            ret_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            irq_prev_q <= bus.irq;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            ret_pc_q   <= ret_pc_d;
        end
    end

`ifdef IRQ_ZSAVE_EN
    logic z_sav_q, z_sav_d;

    assign z_sav_d = (state_q == ENTER) ? bus.z_in : z_sav_q;

    // Z snapshot taken in the entry cycle, held until the next entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_sav_q <= 1'b0;
        end else begin
            z_sav_q <= z_sav_d;
        end
    end

    assign bus.z_restore = reti;
    assign bus.z_out     = reti & z_sav_q;
`else
    logic unused_z_in;
    logic unused_reti;
    assign unused_z_in   = bus.z_in;
    assign unused_reti   = reti;
    assign bus.z_restore = 1'b0;
    assign bus.z_out     = 1'b0;
`endif

    assign bus.s_irq      = s_irq;
    assign bus.pc_irq     = pc_irq;
    assign bus.irq_ack    = irq_ack;
    assign bus.in_service = in_service;

endmodule
